// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined 4-bit-group carry-lookahead adder/subtractor
// Stage k sums group k using the group carry registered by stage k-1. Upper
// operand groups ride forward in skew registers that shrink by one group per
// stage; finished sum groups accumulate in deskew registers that grow by one
// group per stage, so the whole result leaves stage G-1 together.
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int G = WIDTH / 4;

  logic stall;

  // Single-level lookahead over one 4-bit group: returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c);
    return {c4, p ^ {c3, c2, c1, c}};
  endfunction

  genvar k;
  generate
    for (k = 0; k < G; k++) begin : g_stage
      localparam int SW = 4 * (k + 1);   // sum bits finished after this stage
      localparam int RW = WIDTH - SW;    // operand bits still waiting to be summed

      logic [3:0]    a_in;
      logic [3:0]    b_in;
      logic          c_in;
      logic          v_in;
      logic [4:0]    r;
      logic [SW-1:0] sum_nx;
      logic          valid_d, valid_q;
      logic          carry_d, carry_q;
      logic [SW-1:0] sum_d, sum_q;

      assign r = cla4(a_in, b_in, c_in);

      // B is inverted once on entry so later stages never see in_sub.
      if (k == 0) begin : g_src
        assign a_in   = in_a[3:0];
        assign b_in   = in_b[3:0] ^ {4{in_sub}};
        assign c_in   = in_cin ^ in_sub;
        assign v_in   = in_valid;
        assign sum_nx = r[3:0];
      end else begin : g_src
        assign a_in   = g_stage[k-1].g_ops.a_q[3:0];
        assign b_in   = g_stage[k-1].g_ops.b_q[3:0];
        assign c_in   = g_stage[k-1].carry_q;
        assign v_in   = g_stage[k-1].valid_q;
        assign sum_nx = {r[3:0], g_stage[k-1].sum_q};
      end

      if (RW > 0) begin : g_ops
        logic [RW-1:0] a_nx, b_nx;
        logic [RW-1:0] a_d, a_q;
        logic [RW-1:0] b_d, b_q;

        if (k == 0) begin : g_osrc
          assign a_nx = in_a[WIDTH-1:4];
          assign b_nx = in_b[WIDTH-1:4] ^ {RW{in_sub}};
        end else begin : g_osrc
          assign a_nx = g_stage[k-1].g_ops.a_q[RW+3:4];
          assign b_nx = g_stage[k-1].g_ops.b_q[RW+3:4];
        end

        // Skew registers: take the remaining upper groups unless stalled.
        always_comb begin
          a_d = stall ? a_q : a_nx;
          b_d = stall ? b_q : b_nx;
        end

        // Skew register state.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_q <= '0;
            b_q <= '0;
          end else begin
            a_q <= a_d;
            b_q <= b_d;
          end
        end
      end

      // Stage valid, group carry and deskewed sum; everything holds on stall.
      always_comb begin
        valid_d = stall ? valid_q : v_in;
        carry_d = stall ? carry_q : r[4];
        sum_d   = stall ? sum_q   : sum_nx;
      end

      // Stage state; reset discards in-flight beats immediately.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          sum_q   <= '0;
        end else begin
          valid_q <= valid_d;
          carry_q <= carry_d;
          sum_q   <= sum_d;
        end
      end

      if (k == G - 1) begin : g_last
        logic ovf_d, ovf_q;
        logic zero_d, zero_q;

        // Carry into the MSB is recovered as s3 ^ a3 ^ b3 of the top group.
        always_comb begin
          ovf_d  = stall ? ovf_q  : (r[3] ^ a_in[3] ^ b_in[3] ^ r[4]);
          zero_d = stall ? zero_q : ~|sum_nx;
        end

        // Registered flags so they reset to 0 alongside out_sum.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
          end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[G-1].valid_q;
  assign out_sum   = g_stage[G-1].sum_q;
  assign out_cout  = g_stage[G-1].carry_q;
  assign out_ovf   = g_stage[G-1].g_last.ovf_q;
  assign out_zero  = g_stage[G-1].g_last.zero_q;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - randomized self-checking bench for cla_addsub_pipe
module tb_cla_addsub_pipe;

  localparam int W = 16;
  localparam int G = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected pipeline occupancy: slot G-1 is what the outputs should show.
  logic         mv [G];
  logic [W+2:0] mr [G];
  logic         last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: {zero, ovf, cout, sum}.
  function automatic logic [W+2:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s, input logic c);
    longint ua, ub, sa, sb, u, sr, lim;
    logic co;
    logic [W-1:0] sum;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (!s) begin
      u  = ua + ub + longint'(c);
      co = (u >= (longint'(1) << W));
      sr = sa + sb + longint'(c);
    end else begin
      u  = ua - ub - longint'(c);
      co = (ua >= ub + longint'(c));
      sr = sa - sb - longint'(c);
    end
    sum = u[W-1:0];
    return {sum == '0, (sr >= lim) || (sr < -lim), co, sum};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom());
    endcase
  endfunction

  // One clock: drive at the falling edge, check in_ready, advance the model,
  // then check the outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c, input logic ordy);
    logic stall_m;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sub    = s;
    in_cin    = c;
    out_ready = ordy;
    #1;
    stall_m = mv[G-1] & ~ordy;
    check("in_ready", in_ready, !stall_m);
    last_acc = v & ~stall_m;
    if (!stall_m) begin
      for (int i = G - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = v;
      mr[0] = ref_model(a, b, s, c);
    end
    @(negedge clk);
    check("out_valid", out_valid, mv[G-1]);
    if (mv[G-1])
      check("result", {out_zero, out_ovf, out_cout, out_sum}, mr[G-1]);
  endtask

  task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                     input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
    cycle(1'b1, a, b, s, c, 1'b1);
    repeat (G - 1) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("dir_valid", out_valid, 1'b1);
    check("dir_sum", out_sum, es);
    check("dir_cout", out_cout, ec);
    check("dir_ovf", out_ovf, eo);
    check("dir_zero", out_zero, ez);
  endtask

  task automatic clear_model();
    for (int i = 0; i < G; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end
  endtask

  initial begin
    int acc;
    int cyc;
    clear_model();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, '0);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    dir(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    dir(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    dir(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    dir(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    acc = 0;
    cyc = 0;
    while (acc < 64 && cyc < 2000) begin
      cyc++;
      cycle($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (last_acc) acc++;
    end
    check("rand_accepted", acc, 64);
    repeat (40) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    repeat (G) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    acc = 0;
    repeat (200) begin
      cycle(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      if (last_acc) acc++;
    end
    check("full_rate_accepted", acc, 200);
    repeat (G) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    repeat (G + 2) cycle(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b1);
    check("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_sum", out_sum, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    repeat (G + 2) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    dir(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
